macc_frame_accum: RTL and testbench
===================================

// Module: macc_frame_accum
// PURPOSE
//   Downstream stage of the registered MACC pipeline. Consumes the 48-bit product stream P
//   and sums a programmable number of consecutive samples into one frame total.
//   Sits between the MACC output register and the result FIFO/bus.
//   Uses a valid/ready handshake on both sides, and supports an early flush and optional saturation.
// PARAMETERS
//   IN_W     48  width of incoming product (unsigned)
//   ACC_W    56  accumulator / output width, ACC_W >= IN_W
//   CNT_W    8   width of frame length and sample counter
//   SATURATE 1   1: clamp accumulator to all-ones on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//   CLK        in   1      clock, all logic on posedge
//   RST        in   1      reset, synchronous, active-low
//   len        in   CNT_W  samples per frame, sampled on first accepted sample; 0 treated as 1
//   flush      in   1      close current frame early (effective only in ACC)
//   in_valid   in   1      in_data valid
//   in_ready   out  1      stage can accept in_data
//   in_data    in   IN_W   product sample from MACC P
//   out_valid  out  1      frame result valid
//   out_ready  in   1      consumer accepts result
//   out_sum    out  ACC_W  frame total
//   out_count  out  CNT_W  samples actually summed into out_sum
//   out_ovf    out  1      sticky: overflow occurred within this frame
// BEHAVIOUR
//   - Reset (RST==0 at posedge): state=IDLE, acc=0, cnt=0, len_q=0, out_ovf=0. Outputs are
//     out_valid=0, out_sum=0, out_count=0, in_ready=1. Reset wins over every other input
//     and aborts a frame in progress without emitting it.
//   - Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
//   - The FSM has three states: IDLE, ACC and OUT.
//   - IDLE: in_ready=1, out_valid=0. On input accept:
//     - acc <= in_data (zero-extended), cnt <= 1, ovf <= 0, len_q <= (len==0 ? 1 : len).
//     - Next state is OUT if that effective length is 1, else ACC.
//     - flush in IDLE is ignored.
//   - ACC: in_ready=1, out_valid=0. On input accept:
//     - acc <= acc + in_data and cnt <= cnt+1.
//     - Carry out of ACC_W sets ovf. With SATURATE=1, acc <= {ACC_W{1'b1}}, and stays
//       saturated for the rest of the frame.
//     - Next state is OUT when cnt+1 == len_q.
//   - ACC flush: flush=1 moves to OUT.
//     - If an input is accepted in the same cycle, it is included first (sum and count).
//     - If no input is accepted, the partial sum is emitted with out_count=cnt.
//   - OUT: in_ready=0, out_valid=1, out_sum=acc, out_count=cnt, out_ovf=ovf.
//     - Outputs hold stable until accepted.
//     - On output accept, next state is IDLE; out_valid drops the following cycle.
//     - flush and len are ignored in OUT.
//   - Latency: out_valid is asserted the cycle after the final sample (or flush) is accepted.
//     There is a minimum 1-cycle input bubble per frame (the OUT state).
//   - Arithmetic is unsigned. The sum is computed at ACC_W+1 bits; bit ACC_W is the overflow carry.
//   - Counter: cnt never exceeds len_q. len_q = 2^CNT_W-1 is the maximum frame length.
//   - A change on len mid-frame has no effect until the next frame's first sample.
// TESTING
//   1. len=4; inputs 10,20,30,40 back-to-back; out_ready=1 -> one cycle after the 4th accept:
//      out_sum=100, out_count=4, out_ovf=0.
//   2. len=0; single input 0x123 -> out_sum=0x123, out_count=1, with in_ready=0 while OUT is pending.
//   3. len=8; inputs 5,5,5, then flush with a 4th input 5 in the same cycle -> out_sum=20,
//      out_count=4; flush asserted alone in IDLE -> no output.
//   4. ACC_W=48, SATURATE=1, len=2; inputs 2^48-1 and 2 -> out_sum=2^48-1, out_ovf=1.
//      With SATURATE=0 -> out_sum=1, out_ovf=1.
//   5. len=3; out_ready=0 for 5 cycles after the frame completes -> out_valid stays high, outputs
//      are stable, in_ready=0, in_valid is ignored; out_ready=1 -> IDLE the next cycle.
//   6. len=4; 2 samples accepted, then RST=0 for 1 cycle -> all outputs reset with no frame
//      emitted; a following frame of 1,2,3,4 -> out_sum=10.

Source files
------------

// File: rtl/macc_frame_accum.sv
// Frame accumulator after the MACC product register: sums len consecutive products
// into one frame total, with early flush, optional saturation and valid/ready on both sides.
module macc_frame_accum #(
    parameter int IN_W     = 48,
    parameter int ACC_W    = 56,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CNT_W-1:0] len,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic             ovf;

    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] len_eff;
    logic             in_acc;

    // One extra bit on the adder so the carry out of ACC_W flags overflow.
    assign sum      = {1'b0, acc} + (ACC_W+1)'(in_data);
    assign cnt_next = cnt + CNT_W'(1);
    assign len_eff  = (len == '0) ? CNT_W'(1) : len;
    assign in_acc   = in_valid & in_ready;

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_acc) begin
                        acc   <= ACC_W'(in_data);
                        cnt   <= CNT_W'(1);
                        ovf   <= 1'b0;
                        len_q <= len_eff;
                        if (len_eff == CNT_W'(1)) begin
                            state     <= OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    // A sample arriving with flush is folded in before the frame closes.
                    if (in_acc) begin
                        if (sum[ACC_W]) begin
                            ovf <= 1'b1;
                            acc <= SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        cnt <= cnt_next;
                    end
                    if (flush || (in_acc && cnt_next == len_q)) begin
                        state     <= OUT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macc_frame_accum.sv
// Scoreboard bench for macc_frame_accum: one default instance plus two 48-bit
// instances (saturating and wrapping) all driven by the same stimulus.
module tb_macc_frame_accum;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_ovf;
    logic [55:0] out_sum;
    logic [7:0]  out_count;

    logic        sat_in_ready, sat_out_valid, sat_out_ovf;
    logic [47:0] sat_out_sum;
    logic [7:0]  sat_out_count;

    logic        wrap_in_ready, wrap_out_valid, wrap_out_ovf;
    logic [47:0] wrap_out_sum;
    logic [7:0]  wrap_out_count;

    always #5 CLK = ~CLK;

    macc_frame_accum dut (
        .CLK(CLK), .RST(RST), .len(len), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    macc_frame_accum #(.IN_W(48), .ACC_W(48), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
        .CLK(CLK), .RST(RST), .len(len), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_sum(sat_out_sum), .out_count(sat_out_count), .out_ovf(sat_out_ovf)
    );

    macc_frame_accum #(.IN_W(48), .ACC_W(48), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
        .CLK(CLK), .RST(RST), .len(len), .flush(flush),
        .in_valid(in_valid), .in_ready(wrap_in_ready), .in_data(in_data),
        .out_valid(wrap_out_valid), .out_ready(out_ready),
        .out_sum(wrap_out_sum), .out_count(wrap_out_count), .out_ovf(wrap_out_ovf)
    );

    typedef struct {
        logic [55:0] s56;
        logic [47:0] s48s;
        logic [47:0] s48w;
        logic [7:0]  cnt;
        logic        o56;
        logic        o48s;
        logic        o48w;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    int          m_cnt = 0;
    int          m_len = 0;
    logic [55:0] a56;
    logic [47:0] a48s, a48w;
    logic        o56, o48s, o48w;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference arithmetic for all three configurations on one accepted sample.
    task automatic addSample(input logic [47:0] d);
        logic [56:0] s57;
        logic [48:0] s49;
        s57 = {1'b0, a56} + {9'b0, d};
        if (s57[56]) begin o56 = 1'b1; a56 = '1; end else a56 = s57[55:0];
        s49 = {1'b0, a48s} + {1'b0, d};
        if (s49[48]) begin o48s = 1'b1; a48s = '1; end else a48s = s49[47:0];
        s49 = {1'b0, a48w} + {1'b0, d};
        if (s49[48]) o48w = 1'b1;
        a48w = s49[47:0];
    endtask

    task automatic closeFrame();
        exp_t e;
        e.s56 = a56; e.s48s = a48s; e.s48w = a48w; e.cnt = 8'(m_cnt);
        e.o56 = o56; e.o48s = o48s; e.o48w = o48w;
        exp_q.push_back(e);
        m_cnt = 0;
        @(negedge CLK);
        #2;
        checkOutput("latency_valid", 64'(out_valid), 64'd1);
        checkOutput("out_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic applyStimulus(input logic [47:0] d, input logic fl);
        int w;
        logic first;
        @(negedge CLK);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (w == 50) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        first    = (m_cnt == 0);
        if (first) begin
            m_len = (len == 8'd0) ? 1 : int'(len);
            a56 = {8'b0, d}; a48s = d; a48w = d;
            o56 = 1'b0; o48s = 1'b0; o48w = 1'b0;
            m_cnt = 1;
        end else begin
            addSample(d);
            m_cnt++;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        if (m_cnt == m_len || (fl && !first)) closeFrame();
    endtask

    task automatic flushOnly();
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        if (m_cnt != 0) closeFrame();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_sum"}, 64'(out_sum), 64'd0);
        checkOutput({tag, "_count"}, 64'(out_count), 64'd0);
        checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'd0);
    endtask

    // Pops one expected frame per output handshake and compares all three instances.
    always @(negedge CLK) begin
        #1;
        if (RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_output", 64'(out_sum), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sum56", 64'(out_sum), 64'(e.s56));
                checkOutput("count56", 64'(out_count), 64'(e.cnt));
                checkOutput("ovf56", 64'(out_ovf), 64'(e.o56));
                checkOutput("valid48", 64'({sat_out_valid, wrap_out_valid}), 64'd3);
                checkOutput("sum48sat", 64'(sat_out_sum), 64'(e.s48s));
                checkOutput("ovf48sat", 64'(sat_out_ovf), 64'(e.o48s));
                checkOutput("sum48wrap", 64'(wrap_out_sum), 64'(e.s48w));
                checkOutput("ovf48wrap", 64'(wrap_out_ovf), 64'(e.o48w));
                checkOutput("count48", 64'(wrap_out_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        repeat (3) @(negedge CLK);
        #2;
        checkIdle("reset");
        @(negedge CLK);
        RST = 1'b1;

        // Plain four-sample frame, back to back.
        len = 8'd4;
        applyStimulus(48'd10, 1'b0);
        applyStimulus(48'd20, 1'b0);
        applyStimulus(48'd30, 1'b0);
        applyStimulus(48'd40, 1'b0);

        // Zero length behaves as one.
        len = 8'd0;
        applyStimulus(48'h123, 1'b0);

        // Early flush with a sample in the same cycle, then a flush with nothing open.
        len = 8'd8;
        applyStimulus(48'd5, 1'b0);
        applyStimulus(48'd5, 1'b0);
        applyStimulus(48'd5, 1'b0);
        len = 8'd2;
        applyStimulus(48'd5, 1'b1);
        flushOnly();
        @(negedge CLK);
        @(negedge CLK);
        #2;
        checkOutput("idle_flush_valid", 64'(out_valid), 64'd0);

        // Flush without a sample emits the partial sum.
        len = 8'd6;
        applyStimulus(48'd7, 1'b0);
        applyStimulus(48'd9, 1'b0);
        flushOnly();

        // Overflow at 48 bits: saturate vs wrap; fits in 56 bits.
        len = 8'd2;
        applyStimulus(48'hFFFF_FFFF_FFFF, 1'b0);
        applyStimulus(48'd2, 1'b0);
        len = 8'd3;
        applyStimulus(48'hFFFF_FFFF_FFF0, 1'b0);
        applyStimulus(48'h20, 1'b0);
        applyStimulus(48'd0, 1'b0);

        // Back-pressure: result held while the consumer stalls, inputs ignored.
        len = 8'd3;
        @(negedge CLK);
        out_ready = 1'b0;
        applyStimulus(48'd1, 1'b0);
        applyStimulus(48'd2, 1'b0);
        applyStimulus(48'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_data  = 48'd99;
            #2;
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_sum", 64'(out_sum), 64'd6);
            checkOutput("hold_count", 64'(out_count), 64'd3);
            checkOutput("hold_ready", 64'(in_ready), 64'd0);
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        #2;
        checkOutput("release_valid", 64'(out_valid), 64'd0);
        checkOutput("release_ready", 64'(in_ready), 64'd1);

        // Reset aborts a frame in progress without emitting it.
        len = 8'd4;
        applyStimulus(48'd7, 1'b0);
        applyStimulus(48'd8, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        m_cnt = 0;
        @(negedge CLK);
        RST = 1'b1;
        #2;
        checkIdle("abort");
        applyStimulus(48'd1, 1'b0);
        applyStimulus(48'd2, 1'b0);
        applyStimulus(48'd3, 1'b0);
        applyStimulus(48'd4, 1'b0);

        // Maximum frame length.
        len = 8'd255;
        for (int i = 0; i < 255; i++) applyStimulus(48'(i + 1), 1'b0);

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
